adc_lane_serializer: RTL and testbench

- Single-clock, parametrised parallel-to-serial gearbox for I/Q ADC data.
- Accepts words of LANES packed samples per channel through a valid/ready handshake and buffers them in a DEPTH-word FIFO.
- Emits one I/Q sample per accepted output beat, with a runtime-selectable lane order.
- Sits in the clkin320 domain after the ADC capture logic. It replaces fixed 2:1 muxing where the producer can run at 1/LANES of the sample rate.

---
 rtl/adc_lane_serializer_if.sv | 33 +++
 rtl/adc_lane_serializer.sv | 151 +++++++++++++++
 tb/tb_adc_lane_serializer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_lane_serializer_if.sv
// Handshake and data bundle for the I/Q lane serializer.
// The master side is the ADC capture / downstream pair; the slave side is the serializer.
interface adc_lane_serializer_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  parameter int DEPTH = 4
);
  localparam int LVLW = $clog2(DEPTH) + 1;

  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*WIDTH-1:0]   i_in;
  logic [LANES*WIDTH-1:0]   q_in;
  logic                     lane_rev;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         i_out;
  logic [WIDTH-1:0]         q_out;
  logic                     out_first;
  logic [LVLW-1:0]          level;
  logic                     overflow;
  logic                     overflow_clr;

  modport master (
    output in_valid, i_in, q_in, lane_rev, out_ready, overflow_clr,
    input  in_ready, out_valid, i_out, q_out, out_first, level, overflow
  );

  modport slave (
    input  in_valid, i_in, q_in, lane_rev, out_ready, overflow_clr,
    output in_ready, out_valid, i_out, q_out, out_first, level, overflow
  );
endinterface

// File: rtl/adc_lane_serializer.sv
// Parallel-to-serial gearbox for packed I/Q ADC words.
// Words of LANES samples are buffered in a DEPTH-word FIFO and emitted one
// I/Q pair per output beat, lane order selectable per word.
module adc_lane_serializer #(
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  parameter int DEPTH = 4
) (
  input  logic                  clkin320,
  input  logic                  reset,
  adc_lane_serializer_if.slave  bus
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int LIW = $clog2(LANES);
  localparam int WW  = 2 * LANES * WIDTH;

  localparam logic [PW-1:0]  PTR_ONE   = PW'(1);
  localparam logic [LIW-1:0] LANE_ONE  = LIW'(1);
  localparam logic [LIW-1:0] LAST_LANE = LIW'(LANES - 1);

  // FIFO storage and pointers; the extra pointer MSB tells full from empty
  logic [WW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_level;
  logic              r_overflow;

  // Output stage
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_i_out;
  logic [WIDTH-1:0]  r_q_out;
  logic              r_out_first;
  logic [LIW-1:0]    r_lane_idx;
  logic              r_rev;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_drop;
  logic              w_load;
  logic              w_pop;
  logic              w_rev;
  logic [LIW-1:0]    w_lane_sel;
  logic [WW-1:0]     w_head;
  logic [WIDTH-1:0]  w_i_sel;
  logic [WIDTH-1:0]  w_q_sel;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // in_ready looks only at stored state, so a word arriving while full is
  // refused even when the head word pops in the same cycle.
  assign w_push  = bus.in_valid & ~w_full;
  assign w_drop  = bus.in_valid &  w_full;

  assign w_load  = (~r_out_valid | bus.out_ready) & ~w_empty;
  assign w_pop   = w_load & (r_lane_idx == LAST_LANE);

  // Lane order is sampled on the first lane of a word and held for the rest.
  assign w_rev      = (r_lane_idx == '0) ? bus.lane_rev : r_rev;
  assign w_lane_sel = w_rev ? (LAST_LANE - r_lane_idx) : r_lane_idx;
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

  // Pick lane w_lane_sel out of the head word for both channels
  always_comb begin
    w_i_sel = '0;
    w_q_sel = '0;
    for (int k = 0; k < LANES; k++) begin
      if (w_lane_sel == LIW'(k)) begin
        w_i_sel = w_head[k*WIDTH +: WIDTH];
        w_q_sel = w_head[(LANES+k)*WIDTH +: WIDTH];
      end
    end
  end

  // Write accepted words at the tail; storage needs no reset
  always_ff @(posedge clkin320) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {bus.q_in, bus.i_in};
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clkin320 or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + PTR_ONE;
        2'b01:   r_level <= r_level - PTR_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clkin320 or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.overflow_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // Output register, lane sequencing and lane-order capture
  always_ff @(posedge clkin320 or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_i_out     <= '0;
      r_q_out     <= '0;
      r_out_first <= 1'b0;
      r_lane_idx  <= '0;
      r_rev       <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_i_out     <= w_i_sel;
      r_q_out     <= w_q_sel;
      r_out_first <= (r_lane_idx == '0);
      r_rev       <= w_rev;
      if (r_lane_idx == LAST_LANE) begin
        r_lane_idx <= '0;
      end else begin
        r_lane_idx <= r_lane_idx + LANE_ONE;
      end
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = r_out_valid;
  assign bus.i_out     = r_i_out;
  assign bus.q_out     = r_q_out;
  assign bus.out_first = r_out_first;
  assign bus.level     = r_level;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_adc_lane_serializer.sv
// Bench for adc_lane_serializer: table-driven words plus hand-written
// sequences for lane order, overflow, backpressure and mid-word reset.
module tb_adc_lane_serializer;
  localparam int WIDTH = 16;
  localparam int LANES = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_lane_serializer_if #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) bus ();

  adc_lane_serializer #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clkin320 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
    logic        first;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [31:0] i_in;
    logic [31:0] q_in;
    logic        rev;
    logic [15:0] e0_i;
    logic [15:0] e0_q;
    logic [15:0] e1_i;
    logic [15:0] e1_q;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_add2(input logic [15:0] e0i, e0q, e1i, e1q);
    sb.push_back('{e0i, e0q, 1'b1});
    sb.push_back('{e1i, e1q, 1'b0});
  endtask

  // Reference ordering of a word's two lanes
  task automatic expect_word(input logic [31:0] iw, input logic [31:0] qw, input logic rev);
    logic [15:0] i0, i1, q0, q1;
    i0 = iw[15:0];  i1 = iw[31:16];
    q0 = qw[15:0];  q1 = qw[31:16];
    if (!rev) sb_add2(i0, q0, i1, q1);
    else      sb_add2(i1, q1, i0, q0);
  endtask

  // Present one word for one cycle; called just after a rising edge
  task automatic drive(input logic [31:0] iw, input logic [31:0] qw, input logic rev,
                       input logic acc);
    bus.in_valid = 1'b1;
    bus.i_in     = iw;
    bus.q_in     = qw;
    bus.lane_rev = rev;
    @(negedge clk);
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, acc});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_within_bound", {31'd0, n < 200}, 32'd1);
  endtask

  // Scoreboard: every presented sample must match the queue head; pop on handshake
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_sample", 32'd1, 32'd0);
      end else begin
        chk("i_out",     {16'd0, bus.i_out},     {16'd0, sb[0].i});
        chk("q_out",     {16'd0, bus.q_out},     {16'd0, sb[0].q});
        chk("out_first", {31'd0, bus.out_first}, {31'd0, sb[0].first});
        if (bus.out_ready) sb.delete(0);
      end
    end
  end

  initial begin
    logic [15:0] a, b;
    logic [31:0] iw, qw;

    tbl[0] = '{32'h0002_0001, 32'h000B_000A, 1'b0, 16'h0001, 16'h000A, 16'h0002, 16'h000B};
    tbl[1] = '{32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
    tbl[2] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 16'h5678, 16'hDEF0, 16'h1234, 16'h9ABC};
    tbl[3] = '{32'hCAFE_BEEF, 32'hDEAD_F00D, 1'b1, 16'hCAFE, 16'hDEAD, 16'hBEEF, 16'hF00D};
    tbl[4] = '{32'h8000_7FFF, 32'h0001_FFFE, 1'b0, 16'h7FFF, 16'hFFFE, 16'h8000, 16'h0001};

    bus.in_valid     = 1'b0;
    bus.i_in         = '0;
    bus.q_in         = '0;
    bus.lane_rev     = 1'b0;
    bus.out_ready    = 1'b1;
    bus.overflow_clr = 1'b0;

    // Reset values
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_i_out",     {16'd0, bus.i_out},     32'd0);
    chk("rst_q_out",     {16'd0, bus.q_out},     32'd0);
    chk("rst_out_first", {31'd0, bus.out_first}, 32'd0);
    chk("rst_level",     {29'd0, bus.level},     32'd0);
    chk("rst_overflow",  {31'd0, bus.overflow},  32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Basic serialization with cycle-accurate latency and level
    expect_word(32'h2222_1111, 32'hBBBB_AAAA, 1'b0);
    drive(32'h2222_1111, 32'hBBBB_AAAA, 1'b0, 1'b1);
    chk("t1_level_push", {29'd0, bus.level},     32'd1);
    chk("t1_valid_t0",   {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk("t1_valid_t1",   {31'd0, bus.out_valid}, 32'd1);
    chk("t1_first_t1",   {31'd0, bus.out_first}, 32'd1);
    chk("t1_level_t1",   {29'd0, bus.level},     32'd1);
    tick();
    chk("t1_valid_t2",   {31'd0, bus.out_valid}, 32'd1);
    chk("t1_first_t2",   {31'd0, bus.out_first}, 32'd0);
    chk("t1_level_t2",   {29'd0, bus.level},     32'd0);
    tick();
    chk("t1_valid_t3",   {31'd0, bus.out_valid}, 32'd0);
    wait_idle();

    // Reversed lane order; flipping lane_rev mid-word must not matter
    expect_word(32'h2222_1111, 32'hBBBB_AAAA, 1'b1);
    drive(32'h2222_1111, 32'hBBBB_AAAA, 1'b1, 1'b1);
    tick();
    bus.lane_rev = 1'b0;
    wait_idle();

    // Table-driven words
    for (int v = 0; v < 5; v++) begin
      sb_add2(tbl[v].e0_i, tbl[v].e0_q, tbl[v].e1_i, tbl[v].e1_q);
      drive(tbl[v].i_in, tbl[v].q_in, tbl[v].rev, 1'b1);
      wait_idle();
    end

    // Overflow: fill with output stalled, drop the fifth word, then drain
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a = 16'h1000 + 16'(k);
      b = 16'h2000 + 16'(k);
      iw = {b, a};
      qw = {~b, ~a};
      expect_word(iw, qw, 1'b0);
      drive(iw, qw, 1'b0, 1'b1);
    end
    chk("t3_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
    chk("t3_level_full",    {29'd0, bus.level},    32'd4);
    drive(32'h5555_5555, 32'h5555_5555, 1'b0, 1'b0);
    chk("t3_overflow",      {31'd0, bus.overflow}, 32'd1);
    chk("t3_level_after",   {29'd0, bus.level},    32'd4);
    bus.out_ready = 1'b1;
    wait_idle();
    chk("t3_level_drained", {29'd0, bus.level},    32'd0);

    // Clear priority
    bus.overflow_clr = 1'b1;
    tick();
    bus.overflow_clr = 1'b0;
    chk("t5_clr_alone_a", {31'd0, bus.overflow}, 32'd0);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a = 16'h3000 + 16'(k);
      b = 16'h4000 + 16'(k);
      iw = {b, a};
      qw = {a, b};
      expect_word(iw, qw, 1'b0);
      drive(iw, qw, 1'b0, 1'b1);
    end
    bus.overflow_clr = 1'b1;
    drive(32'h7777_7777, 32'h7777_7777, 1'b0, 1'b0);
    bus.overflow_clr = 1'b0;
    chk("t5_set_wins", {31'd0, bus.overflow}, 32'd1);
    bus.overflow_clr = 1'b1;
    tick();
    bus.overflow_clr = 1'b0;
    chk("t5_clr_alone_b", {31'd0, bus.overflow}, 32'd0);
    bus.out_ready = 1'b1;
    wait_idle();

    // Backpressure: pushes every other cycle while out_ready toggles
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          int n;
          n = 0;
          while (!bus.in_ready && n < 50) begin
            tick();
            n++;
          end
          chk("t4_in_ready_wait", {31'd0, n < 50}, 32'd1);
          a = 16'h6000 + 16'(k);
          b = 16'h7000 + 16'(k);
          iw = {b, a};
          qw = {a ^ 16'h00FF, b ^ 16'hFF00};
          expect_word(iw, qw, 1'b1);
          drive(iw, qw, 1'b1, 1'b1);
          tick();
        end
      end
      begin
        repeat (30) begin
          tick();
          bus.out_ready = ~bus.out_ready;
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_idle();

    // Reset in the middle of a word with more words queued
    bus.out_ready = 1'b0;
    expect_word(32'h6666_5555, 32'hEEEE_DDDD, 1'b0);
    drive(32'h6666_5555, 32'hEEEE_DDDD, 1'b0, 1'b1);
    expect_word(32'h8888_7777, 32'h1111_9999, 1'b0);
    drive(32'h8888_7777, 32'h1111_9999, 1'b0, 1'b1);
    tick();
    chk("t6_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid",    {31'd0, bus.out_valid}, 32'd0);
    chk("t6_rst_level",    {29'd0, bus.level},     32'd0);
    chk("t6_rst_in_ready", {31'd0, bus.in_ready},  32'd1);
    sb.delete();
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    expect_word(32'h4444_3333, 32'hDDDD_CCCC, 1'b0);
    drive(32'h4444_3333, 32'hDDDD_CCCC, 1'b0, 1'b1);
    tick();
    chk("t6_first_i",    {16'd0, bus.i_out},     32'h0000_3333);
    chk("t6_first_flag", {31'd0, bus.out_first}, 32'd1);
    wait_idle();

    chk("sb_empty_end", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
